// File: rtl/dmem_pkg.sv
// dmem_pkg: access-type encodings, arbiter state enum and byte-count helpers
// Used by dmem_arbiter; no ports.
package dmem_pkg;

    localparam logic [2:0] CT_B  = 3'b000;
    localparam logic [2:0] CT_H  = 3'b001;
    localparam logic [2:0] CT_W  = 3'b010;
    localparam logic [2:0] CT_BU = 3'b100;
    localparam logic [2:0] CT_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

    function automatic logic [2:0] byte_cnt(input logic [2:0] ctrl);
        return (ctrl == CT_W) ? 3'd4 : (ctrl == CT_H || ctrl == CT_HU) ? 3'd2 : 3'd1;
    endfunction

    function automatic logic ctrl_bad(input logic [2:0] ctrl);
        return !(ctrl inside {CT_B, CT_H, CT_W, CT_BU, CT_HU});
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with remembered last winner
// Ports: clk, rst_n (async, active-low); req[1:0] requests; take = a grant is
// consumed this cycle; gnt[1:0] one-hot combinational grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    // 1 = requester 1 was granted most recently; reset so requester 0 wins the first tie
    logic last;

    always_comb gnt = (&req) ? (last ? 2'b01 : 2'b10) : req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (take && |req)
            last <= gnt[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two requesters sharing a byte-wide data memory, one byte per cycle
// Ports: clk, rst_n (async, active-low); m0_*/m1_* requester handshakes
// (req/we/ctrl/addr/wdata in, ack/err/rdata out); mem_en/mem_we/mem_addr/
// mem_wdata/mem_rdata byte-memory port (read data one cycle after issue); busy.
import dmem_pkg::*;

module dmem_arbiter #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [2:0]        m0_ctrl,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [2:0]        m1_ctrl,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [31:0]       m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    state_t              state, next;
    logic [1:0]          gnt;
    logic                sel, we_q, err_q, c_we, c_bad;
    logic [2:0]          ctrl_q, c_ctrl, cnt, n;
    logic [1:0]          idx;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q, result, ext, c_addr;
    logic [32:0]         c_end;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({m1_req, m0_req}),
        .take  (state == IDLE),
        .gnt   (gnt)
    );

    always_comb begin
        c_we   = gnt[1] ? m1_we   : m0_we;
        c_ctrl = gnt[1] ? m1_ctrl : m0_ctrl;
        c_addr = gnt[1] ? m1_addr : m0_addr;
        // last byte address computed one bit wider so a wrap past 2**32 still flags
        c_end  = {1'b0, c_addr} + 33'(byte_cnt(c_ctrl)) - 33'd1;
        c_bad  = ctrl_bad(c_ctrl) || (c_we && c_ctrl[2]) || ((c_end >> ADDR_W) != 33'd0);
        n      = byte_cnt(ctrl_q);
        // load byte issued last cycle lands now: it is byte cnt-1 (DRAIN sees cnt == N)
        idx    = cnt[1:0] - 2'd1;
        next   = state;
        case (state)
            IDLE:    if (|gnt) next = c_bad ? RESP : XFER;
            XFER:    if (cnt == n - 3'd1) next = we_q ? RESP : DRAIN;
            DRAIN:   next = RESP;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            ctrl_q  <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            cnt     <= 3'd0;
            result  <= 32'd0;
        end else begin
            state <= next;
            if (state == IDLE && |gnt) begin
                sel     <= gnt[1];
                we_q    <= c_we;
                ctrl_q  <= c_ctrl;
                addr_q  <= c_addr[ADDR_W-1:0];
                wdata_q <= gnt[1] ? m1_wdata : m0_wdata;
                err_q   <= c_bad;
                cnt     <= 3'd0;
                result  <= 32'd0;
            end
            if (state == XFER)
                cnt <= cnt + 3'd1;
            if (!we_q && ((state == XFER && cnt != 3'd0) || state == DRAIN))
                result[{idx, 3'b000} +: 8] <= mem_rdata;
        end
    end

    always_comb begin
        mem_en    = state == XFER;
        mem_we    = mem_en && we_q;
        mem_addr  = addr_q + ADDR_W'(cnt);
        mem_wdata = wdata_q[{cnt[1:0], 3'b000} +: 8];
        busy      = state != IDLE;
        // unsigned and word loads need no change: bytes above N stay zero from grant
        ext       = (ctrl_q == CT_B) ? {{24{result[7]}}, result[7:0]} :
                    (ctrl_q == CT_H) ? {{16{result[15]}}, result[15:0]} : result;
        m0_ack    = state == RESP && !sel;
        m1_ack    = state == RESP && sel;
        m0_err    = m0_ack && err_q;
        m1_err    = m1_ack && err_q;
        m0_rdata  = (m0_ack && !err_q && !we_q) ? ext : 32'd0;
        m1_rdata  = (m1_ack && !err_q && !we_q) ? ext : 32'd0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a reference model
module tb_dmem_arbiter;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_init = 1'b1;
    logic          req [2];
    logic          we [2];
    logic [2:0]    ctrl [2];
    logic [31:0]   addr [2];
    logic [31:0]   wdata [2];
    logic          m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;
    logic [7:0]    phys [128];
    logic [7:0]    refm [128];
    int            checks = 0;
    int            failures = 0;

    dmem_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m0_we(we[0]), .m0_ctrl(ctrl[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(req[1]), .m1_we(we[1]), .m1_ctrl(ctrl[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // byte memory seen by the DUT; never cleared by rst_n
    always @(posedge clk) begin
        if (mem_init)
            for (int a = 0; a < 128; a++) phys[a] <= 8'(a * 37 + 5);
        else if (mem_en && mem_we)
            phys[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we)
            mem_rdata <= phys[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ackk(input int k);
        return k == 0 ? m0_ack : m1_ack;
    endfunction

    function automatic logic errk(input int k);
        return k == 0 ? m0_err : m1_err;
    endfunction

    function automatic logic [31:0] rdk(input int k);
        return k == 0 ? m0_rdata : m1_rdata;
    endfunction

    function automatic int nb(input logic [2:0] c);
        return c == 3'b010 ? 4 : (c == 3'b001 || c == 3'b101) ? 2 : 1;
    endfunction

    function automatic bit is_err(input bit w, input logic [2:0] c, input logic [31:0] a);
        return c == 3'b011 || c[2:1] == 2'b11 || (w && c[2]) ||
               ({32'd0, a} + 64'(nb(c)) - 64'd1 > 64'((1 << AW) - 1));
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] c, input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < nb(c); k++) v |= 32'(refm[int'(a[AW-1:0]) + k]) << (8 * k);
        if (c == 3'b000 && v[7])  v |= 32'hFFFF_FF00;
        if (c == 3'b001 && v[15]) v |= 32'hFFFF_0000;
        return v;
    endfunction

    task automatic store_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < nb(c); k++) refm[int'(a[AW-1:0]) + k] = 8'(d >> (8 * k));
    endtask

    task automatic txn(input int k, input bit w, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] d, input string tag, input int exp_lat,
                       input logic [31:0] exp_rd, input bit exp_er);
        int lat, n_en;
        lat = 0;
        n_en = 0;
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; ctrl[k] = c; addr[k] = a; wdata[k] = d;
        while (!ackk(k) && lat < 20) begin
            @(negedge clk);
            lat++;
            if (mem_en) n_en++;
        end
        chk({tag, "_ack"}, 32'(ackk(k)), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(errk(k)), 32'(exp_er));
        chk({tag, "_rdata"}, rdk(k), exp_rd);
        chk({tag, "_other_ack"}, 32'(ackk(1 - k)), 32'd0);
        chk({tag, "_mem_en_cnt"}, 32'(n_en), exp_er ? 32'd0 : 32'(nb(c)));
        req[k] = 1'b0;
    endtask

    initial begin
        int order[$];
        int t, got, g, fe, ackc[2], w;
        bit last, eb, ea;
        logic [31:0] erd[2];
        bit eer[2];
        logic [7:0] old20, old23;

        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; ctrl[k] = 3'd0; addr[k] = 32'd0; wdata[k] = 32'd0;
        end
        for (int a = 0; a < 128; a++) refm[a] = 8'(a * 37 + 5);

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(m1_ack), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        rst_n = 1'b1;
        mem_init = 1'b0;

        txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "st_word", 5, 32'd0, 1'b0);
        store_ref(3'b010, 32'h10, 32'hDEADBEEF);
        chk("st_word_b0", 32'(phys[16]), 32'hEF);
        chk("st_word_b1", 32'(phys[17]), 32'hBE);
        chk("st_word_b2", 32'(phys[18]), 32'hAD);
        chk("st_word_b3", 32'(phys[19]), 32'hDE);

        txn(1, 1'b0, 3'b000, 32'h13, 32'd0, "ld_b", 3, 32'hFFFFFFDE, 1'b0);
        txn(1, 1'b0, 3'b100, 32'h13, 32'd0, "ld_bu", 3, 32'h000000DE, 1'b0);
        txn(0, 1'b0, 3'b010, 32'h7E, 32'd0, "err_rng", 1, 32'd0, 1'b1);
        txn(1, 1'b0, 3'b110, 32'h00, 32'd0, "err_ctrl", 1, 32'd0, 1'b1);
        txn(0, 1'b1, 3'b100, 32'h08, 32'h55, "err_st_u", 1, 32'd0, 1'b1);
        txn(1, 1'b0, 3'b010, 32'h7C, 32'd0, "ld_top", 6, load_val(3'b010, 32'h7C), 1'b0);

        old20 = phys[32];
        old23 = phys[35];
        txn(1, 1'b1, 3'b001, 32'h21, 32'h00001234, "st_half", 3, 32'd0, 1'b0);
        store_ref(3'b001, 32'h21, 32'h1234);
        chk("st_half_21", 32'(phys[33]), 32'h34);
        chk("st_half_22", 32'(phys[34]), 32'h12);
        chk("st_half_20", 32'(phys[32]), 32'(old20));
        chk("st_half_23", 32'(phys[35]), 32'(old23));

        // simultaneous requests, twice: the last grant was m1 so m0 leads each round
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                req[k] = 1'b1; we[k] = 1'b0; ctrl[k] = 3'b100; addr[k] = 32'(5 + k);
            end
            t = 0;
            got = 0;
            while (got < 2 && t < 30) begin
                @(negedge clk);
                t++;
                for (int k = 0; k < 2; k++)
                    if (ackk(k)) begin
                        order.push_back(k);
                        chk("tie_rdata", rdk(k), 32'(refm[5 + k]));
                        req[k] = 1'b0;
                        got++;
                    end
            end
            chk("tie_done", 32'(got), 32'd2);
        end
        for (int j = 0; j < 4; j++)
            chk("tie_order", j < order.size() ? 32'(order[j]) : 32'd9, 32'(j % 2));

        // reset while byte 2 of a word store is on the memory port
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; ctrl[0] = 3'b010; addr[0] = 32'h40; wdata[0] = 32'hA1B2C3D4;
        t = 0;
        while (!(mem_en && mem_addr == 7'h42) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rstx_reach", 32'(t < 20), 32'd1);
        rst_n = 1'b0;
        req[0] = 1'b0;
        #1;
        chk("rstx_busy", 32'(busy), 32'd0);
        chk("rstx_mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        chk("rstx_busy2", 32'(busy), 32'd0);
        chk("rstx_ack", 32'(m0_ack), 32'd0);
        rst_n = 1'b1;
        refm[64] = 8'hD4;
        refm[65] = 8'hC3;
        chk("rstx_b0", 32'(phys[64]), 32'hD4);
        chk("rstx_b1", 32'(phys[65]), 32'hC3);
        chk("rstx_b2", 32'(phys[66]), 32'(refm[66]));
        chk("rstx_b3", 32'(phys[67]), 32'(refm[67]));

        // randomized traffic: model decides grants, latencies and results per cycle
        g = -10;
        fe = -10;
        last = 1'b1;
        ackc[0] = -1;
        ackc[1] = -1;
        @(negedge clk);
        for (int i = 0; i < 640; i++) begin
            for (int k = 0; k < 2; k++) begin
                ea = ackc[k] == i;
                chk($sformatf("r_ack%0d", k), 32'(ackk(k)), 32'(ea));
                if (ea) begin
                    chk($sformatf("r_err%0d", k), 32'(errk(k)), 32'(eer[k]));
                    chk($sformatf("r_rdata%0d", k), rdk(k), erd[k]);
                    req[k] = 1'b0;
                    ackc[k] = -1;
                end
            end
            eb = i >= g && i < fe - 1;
            chk("r_busy", 32'(busy), 32'(eb));
            if (!eb) chk("r_mem_en_idle", 32'(mem_en), 32'd0);
            for (int k = 0; k < 2; k++)
                if (i < 600 && !req[k] && $urandom_range(0, 2) == 0) begin
                    we[k] = 1'($urandom_range(0, 1));
                    ctrl[k] = 3'($urandom_range(0, 7));
                    addr[k] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
                    wdata[k] = $urandom;
                    req[k] = 1'b1;
                end
            if (i + 1 >= fe && (req[0] || req[1])) begin
                w = (req[0] && req[1]) ? (last ? 0 : 1) : (req[1] ? 1 : 0);
                last = w[0];
                g = i + 1;
                eer[w] = is_err(we[w], ctrl[w], addr[w]);
                erd[w] = (eer[w] || we[w]) ? 32'd0 : load_val(ctrl[w], addr[w]);
                if (!eer[w] && we[w]) store_ref(ctrl[w], addr[w], wdata[w]);
                ackc[w] = g + (eer[w] ? 1 : nb(ctrl[w]) + (we[w] ? 1 : 2)) - 1;
                fe = ackc[w] + 2;
            end
            @(negedge clk);
        end
        chk("r_drained", 32'(req[0] || req[1]), 32'd0);
        for (int a = 0; a < 128; a++) chk($sformatf("mem_%02h", a), 32'(phys[a]), 32'(refm[a]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, byte-address width of the shared data memory (2**ADDR_W bytes).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 m0_req / m1_req  input  1  requester k access request, held until acknowledged.
REQ-005 m0_we / m1_we  input  1  1 = store, 0 = load.
REQ-006 m0_ctrl / m1_ctrl  input  3  access type: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-007 m0_addr / m1_addr  input  32  byte address, little-endian.
REQ-008 m0_wdata / m1_wdata  input  32  store data; low N bytes used.
REQ-009 m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-010 m0_err / m1_err  output  1  error flag, valid only with ack.
REQ-011 m0_rdata / m1_rdata  output  32  load result, valid only with ack.
REQ-012 mem_en  output  1  byte memory access enable.
REQ-013 mem_we  output  1  byte memory write enable.
REQ-014 mem_addr  output  ADDR_W  byte memory address.
REQ-015 mem_wdata  output  8  byte write data.
REQ-016 mem_rdata  input  8  byte read data, returned one cycle after mem_en with mem_we=0.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 Requester SHALL hold req, we, ctrl, addr, wdata stable until ack; req still high the cycle after ack is a new request.
REQ-019 In IDLE, a single active req SHALL be granted; with both active, the requester not granted last SHALL win (round-robin).
REQ-020 Request fields SHALL be latched at grant; grant held until RESP completes.
REQ-021 Byte count N: 1 for 000/100, 2 for 001/101, 4 for 010.
REQ-022 Error (no memory access, ack with err=1, rdata=0): ctrl in {011,110,111}; store with ctrl 100/101; addr+N-1 > 2**ADDR_W-1 or addr[31:ADDR_W] nonzero.
REQ-023 States: IDLE, XFER, DRAIN, RESP; IDLE->XFER on legal grant, IDLE->RESP on erroneous grant.
REQ-024 XFER: one mem_en per cycle, byte k (k=0..N-1) at mem_addr=addr+k; store bytes from wdata[8k+7:8k].
REQ-025 After byte N-1: store -> RESP; load -> DRAIN to capture final byte.
REQ-026 Load byte k SHALL be captured into result[8k+7:8k] the cycle after its issue.
REQ-027 Load result: 000/001 sign-extended from bit 8N-1; 100/101 zero-extended; 010 unmodified; store result rdata=0.
REQ-028 RESP: granted requester's ack=1 for exactly one cycle, then IDLE; other ack stays 0.
REQ-029 Latency from grant edge to ack: store N+1 cycles, load N+2, error 1.
REQ-030 mem_en, mem_we SHALL be 0 outside XFER; misaligned legal addresses are permitted.
REQ-031 A request arriving while busy SHALL wait; no request is dropped.

Reset
REQ-032 rst_n low SHALL force state IDLE, all outputs 0, byte counter 0, result 0, last-grant = m1 (m0 wins first tie).
REQ-033 Reset mid-XFER aborts without ack; bytes already written remain (no rollback).

Structure
REQ-034 Shared package dmem_pkg SHALL hold access-type encodings, state enum and byte-count mapping.
REQ-035 Two-way round-robin grant logic SHALL be sub-module rr_arbiter2.

Verification
REQ-036 m0 store word 0xDEADBEEF at 0x10 -> bytes EF,BE,AD,DE at 0x10..0x13, m0_ack 5 cycles after grant, err=0.
REQ-037 m1 load ctrl 000 at 0x13 after REQ-036 -> m1_rdata=0xFFFFFFDE; ctrl 100 -> 0x000000DE; load latency 3.
REQ-038 m0 and m1 request same cycle twice in a row -> grants m0, m1, m0, m1 in order, no lost request.
REQ-039 m0 load word at 0x7E (ADDR_W=7) -> ack 1 cycle after grant, err=1, rdata=0, mem_en never high.
REQ-040 m1 store half 0x1234 at 0x21 -> 34 at 0x21, 12 at 0x22, no write to 0x20/0x23.
REQ-041 rst_n low during byte 2 of word store -> no ack, busy=0 next edge, bytes 0-1 written, bytes 2-3 unchanged.
